// File: rtl/if_stage_pkg.sv
// Shared core package: machine width, reset PC default, system-instruction
// encodings, major opcode constants and the fetch-stage FSM state type.
package if_stage_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Exact encodings of the two instructions that stop fetch
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Major opcodes (bits [6:0]) of the base integer ISA
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Fetch FSM: RUN fetches, DRAIN waits for decode to take the halt
    // instruction, HALT is terminal until reset
    typedef enum logic [1:0] {
        IF_RUN   = 2'd0,
        IF_DRAIN = 2'd1,
        IF_HALT  = 2'd2
    } if_state_e;

    // True for ecall/ebreak; only the full 32-bit encodings match
    function automatic logic is_halt_inst(input logic [31:0] inst);
        return (inst == INST_ECALL) || (inst == INST_EBREAK);
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and holds the fetched word in a valid/ready IF/ID
// register. Redirects from execute flush the held instruction; fetch stops
// after an ecall/ebreak until decode has taken it, then the stage halts.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_inst,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_pc_plus4,
    output logic               halted
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_pc_plus4_q, out_pc_plus4_d;
    logic            halted_q, halted_d;

    logic            accepted;
    logic            load;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;

    // Word address wraps naturally with the memory size
    assign imem_addr       = pc_q[IMEM_AW+1:2];
    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign accepted        = out_valid_q && out_ready;
    assign load            = (state_q == IF_RUN) && (!out_valid_q || out_ready)
                             && !redirect_valid;

    // Next-state, next-PC and IF/ID register update; redirect wins in RUN/DRAIN
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_inst_d     = out_inst_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        halted_d       = halted_q;

        unique case (state_q)
            IF_RUN: begin
                if (redirect_valid) begin
                    pc_d        = redirect_target;
                    out_valid_d = 1'b0;
                end else if (load) begin
                    out_inst_d     = imem_data;
                    out_pc_d       = pc_q;
                    out_pc_plus4_d = pc_plus4;
                    out_valid_d    = 1'b1;
                    if (is_halt_inst(imem_data)) begin
                        state_d = IF_DRAIN;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else if (accepted) begin
                    out_valid_d = 1'b0;
                end
            end
            IF_DRAIN: begin
                if (redirect_valid) begin
                    pc_d        = redirect_target;
                    out_valid_d = 1'b0;
                    state_d     = IF_RUN;
                end else if (accepted) begin
                    out_valid_d = 1'b0;
                    halted_d    = 1'b1;
                    state_d     = IF_HALT;
                end
            end
            IF_HALT: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d = IF_RUN;
            end
        endcase
    end

    // State and IF/ID register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IF_RUN;
            pc_q           <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_inst_q     <= '0;
            out_pc_q       <= '0;
            out_pc_plus4_q <= '0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            out_valid_q    <= out_valid_d;
            out_inst_q     <= out_inst_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            halted_q       <= halted_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_inst     = out_inst_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;
    assign halted       = halted_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the single-issue RISC-V core. It owns the program counter, drives the word address of the combinational instruction memory, and registers the returned instruction into a valid/ready IF/ID register for the decode stage. It accepts redirects from execute (branches, jal/jalr), flushing the in-flight instruction, and stops fetching once an ecall or ebreak has been fetched.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_AW, 6, instruction-memory word-address width (64 words)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, synchronous, active-low (polarity and synchronicity fixed)
- imem_addr  out  IMEM_AW  word address to instruction memory = pc[IMEM_AW+1:2]
- imem_data  in  32  instruction word, combinational from imem_addr
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  IF/ID register holds a valid instruction
- out_ready  in  1  decode accepts the instruction this cycle
- out_inst  out  32  registered instruction
- out_pc  out  32  PC of out_inst
- out_pc_plus4  out  32  out_pc + 4
- halted  out  1  halt instruction has been accepted by decode; sticky until reset

## Operation
- FSM states: RUN, DRAIN, HALT.
- load = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- On load: out_inst<=imem_data, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
- If out_valid && out_ready && !load: out_valid<=0.
- Halt detection: imem_data==32'h00000073 (ecall) or 32'h00100073 (ebreak) on a load -> RUN->DRAIN; pc not advanced.
- DRAIN: no fetch; when out_valid && out_ready (halt instruction accepted) -> HALT, halted<=1, out_valid<=0.
- Redirect (priority over everything in RUN/DRAIN): pc<={redirect_pc[31:2],2'b00}, out_valid<=0, state->RUN. Handshake completing in the same cycle still counts as accepted by decode.
- HALT: redirect_valid ignored; pc, out_* frozen except out_valid=0; exit only by reset.
- fence (opcode 0001111) fetched as an ordinary instruction; no special handling.
- PC arithmetic modulo 2^32; imem_addr wraps modulo 2^IMEM_AW words (pc 0x100 -> word 0).

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC[IMEM_AW+1:2], out_valid=0, out_inst=0, out_pc=0, out_pc_plus4=0, halted=0, state=RUN.
- Fetch latency: instruction at pc visible on out_inst one cycle after the load edge.
- Throughput: one instruction per cycle with out_ready held high.
- Backpressure: out_valid&&!out_ready holds all out_* and pc stable.
- Redirect: new target appears on imem_addr the cycle after redirect_valid; its instruction on out_inst one cycle later (1-cycle bubble).
- halted rises on the edge after the halt instruction's handshake.
- Reset asserted mid-stream overrides all activity at the next edge.

## Structure
- Shared core package: RESET_PC default, XLEN=32, ECALL/EBREAK encodings, opcode constants, FSM state enum.
- No sub-module; the IF/ID register stays inline. Instruction memory is instantiated beside this block at top level, not inside.

## Test plan
- Reset with RESET_PC=0, out_ready=1, memory words 0..3 distinct -> out_pc 0,4,8,12 on consecutive cycles, out_valid rises 1 cycle after reset release.
- out_ready low 3 cycles while out_pc=8 -> out_inst/out_pc stable, imem_addr stays 3, resumes with out_pc=12.
- redirect_valid with redirect_pc=0x13 while out_pc=4 -> out_valid 0 next cycle, then out_pc=0x10, out_pc_plus4=0x14.
- ecall at word 7 -> out_pc=0x1C presented, no further fetch; halted=1 the cycle after acceptance; later redirect ignored.
- ecall fetched then redirect to 0x20 before acceptance -> state RUN, halted stays 0, out_pc=0x20 next.
- Fetch at pc 0xFC then 0x100 -> imem_addr 63 then 0; rst_n low mid-stream -> all outputs reset next edge.
